// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter, its instruction/data requesters and the shared memory.
// The arbiter takes the slave view; the environment (requesters plus memory) takes the master view.
interface mem_arbiter_if;
   logic        i_req_in;
   logic [31:0] i_addr_in;
   logic [31:0] i_rdata_out;
   logic        i_ack_out;

   logic        d_req_in;
   logic        d_we_in;
   logic [31:0] d_addr_in;
   logic [31:0] d_wdata_in;
   logic [3:0]  d_wstrb_in;
   logic [31:0] d_rdata_out;
   logic        d_ack_out;

   logic        mem_req_out;
   logic        mem_we_out;
   logic [31:0] mem_addr_out;
   logic [31:0] mem_wdata_out;
   logic [3:0]  mem_wstrb_out;
   logic [31:0] mem_rdata_in;
   logic        mem_ack_in;

   logic        busy_out;
   logic        err_out;

   modport slave (
      input  i_req_in, i_addr_in,
      input  d_req_in, d_we_in, d_addr_in, d_wdata_in, d_wstrb_in,
      input  mem_rdata_in, mem_ack_in,
      output i_rdata_out, i_ack_out, d_rdata_out, d_ack_out,
      output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
      output busy_out, err_out
   );

   modport master (
      output i_req_in, i_addr_in,
      output d_req_in, d_we_in, d_addr_in, d_wdata_in, d_wstrb_in,
      output mem_rdata_in, mem_ack_in,
      input  i_rdata_out, i_ack_out, d_rdata_out, d_ack_out,
      input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
      input  busy_out, err_out
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data access) arbiter onto a single memory port, with
// round-robin or fixed data priority, a saturating wait counter and a sticky timeout flag.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          D_PRIORITY     = 1'b0
) (
   input logic          sysclk,
   input logic          rst_in,
   mem_arbiter_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

   state_e      state_q, state_d;
   logic        last_d_q, last_d_d;
   logic [31:0] wait_q, wait_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        pick_d;
   logic        timeout;
   logic        finish;
   logic [31:0] fill_data;

   // Both requesting: D wins under fixed priority, else whichever port did not win last time.
   assign pick_d  = bus_io.d_req_in && (!bus_io.i_req_in || D_PRIORITY || !last_d_q);
   assign timeout = (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_CYCLES) && !bus_io.mem_ack_in;
   assign finish  = bus_io.mem_ack_in || timeout;
   // An aborted read returns zero instead of whatever the memory is driving.
   assign fill_data = bus_io.mem_ack_in ? bus_io.mem_rdata_in : 32'h0;

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      wait_d      = wait_q;
      err_d       = err_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (pick_d) begin
               state_d     = StGrantD;
               last_d_d    = 1'b1;
               wait_d      = 32'h0;
               mem_req_d   = 1'b1;
               mem_we_d    = bus_io.d_we_in;
               mem_addr_d  = bus_io.d_addr_in;
               mem_wdata_d = bus_io.d_wdata_in;
               mem_wstrb_d = bus_io.d_wstrb_in;
            end else if (bus_io.i_req_in) begin
               state_d     = StGrantI;
               last_d_d    = 1'b0;
               wait_d      = 32'h0;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus_io.i_addr_in;
               mem_wdata_d = 32'h0;
               mem_wstrb_d = 4'h0;
            end
         end
         StGrantI, StGrantD: begin
            if (finish) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               err_d     = err_q || timeout;
               if (state_q == StGrantI) begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = fill_data;
               end else begin
                  d_ack_d = 1'b1;
                  if (!mem_we_q) begin
                     d_rdata_d = fill_data;
                  end
               end
            end else if (wait_q != 32'hFFFF_FFFF) begin
               wait_d = wait_q + 32'h1;
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge sysclk) begin
      if (rst_in) begin
         state_q     <= StIdle;
         last_d_q    <= 1'b1;
         wait_q      <= 32'h0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'h0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= 32'h0;
         d_rdata_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus_io.i_rdata_out   = i_rdata_q;
   assign bus_io.i_ack_out     = i_ack_q;
   assign bus_io.d_rdata_out   = d_rdata_q;
   assign bus_io.d_ack_out     = d_ack_q;
   assign bus_io.mem_req_out   = mem_req_q;
   assign bus_io.mem_we_out    = mem_we_q;
   assign bus_io.mem_addr_out  = mem_addr_q;
   assign bus_io.mem_wdata_out = mem_wdata_q;
   assign bus_io.mem_wstrb_out = mem_wstrb_q;
   assign bus_io.busy_out      = busy_q;
   assign bus_io.err_out       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin/short-timeout instance checked by a scoreboard, plus a
// fixed-data-priority instance checked by its own expected-grant queue.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if rr_if ();
   mem_arbiter_if fp_if ();

   mem_arbiter #(.TIMEOUT_CYCLES(4), .D_PRIORITY(1'b0)) u_rr (
      .sysclk (clk),
      .rst_in (rst),
      .bus_io (rr_if.slave)
   );

   mem_arbiter #(.TIMEOUT_CYCLES(255), .D_PRIORITY(1'b1)) u_fp (
      .sysclk (clk),
      .rst_in (rst),
      .bus_io (fp_if.slave)
   );

   typedef struct {
      bit          is_d;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      bit          err;
      int          cycles;
   } exp_t;

   exp_t rr_q[$];
   exp_t fp_q[$];
   exp_t rr_e;
   exp_t fp_e;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected model state for the round-robin instance.
   logic [31:0] rr_i_rd = 32'h0;
   logic [31:0] rr_d_rd = 32'h0;
   bit          rr_err  = 1'b0;

   int rr_lat   = 3;
   bit rr_force = 1'b0;
   int rr_cnt   = 0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_5A00);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory models: the rr memory acks on the rr_lat-th cycle of mem_req (never if 0).
   always @(negedge clk) begin
      if (rr_if.mem_req_out) rr_cnt = rr_cnt + 1;
      else rr_cnt = 0;
      rr_if.mem_ack_in   = rr_force || (rr_lat != 0 && rr_cnt == rr_lat);
      rr_if.mem_rdata_in = mem_data(rr_if.mem_addr_out);
   end

   always @(negedge clk) begin
      fp_if.mem_ack_in   = fp_if.mem_req_out;
      fp_if.mem_rdata_in = mem_data(fp_if.mem_addr_out);
   end

   // Scoreboard monitor for the round-robin instance.
   bit rr_req_prev = 1'b0;
   bit rr_ack_prev = 1'b0;
   int rr_req_cyc  = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (rr_if.mem_req_out && !rr_req_prev) begin
            rr_req_cyc = 0;
            if (rr_q.size() == 0) begin
               chk("rr_unexpected_grant", 32'(rr_if.mem_req_out), 32'h0);
            end else begin
               rr_e = rr_q[0];
               chk("rr_mem_addr", rr_if.mem_addr_out, rr_e.addr);
               chk("rr_mem_we", 32'(rr_if.mem_we_out), 32'(rr_e.we));
               chk("rr_mem_wdata", rr_if.mem_wdata_out, rr_e.wdata);
               chk("rr_mem_wstrb", 32'(rr_if.mem_wstrb_out), 32'(rr_e.wstrb));
               chk("rr_busy_in_grant", 32'(rr_if.busy_out), 32'h1);
            end
         end
         if (rr_if.mem_req_out) rr_req_cyc++;
         if (rr_if.i_ack_out || rr_if.d_ack_out) begin
            if (rr_q.size() == 0) begin
               chk("rr_unexpected_ack", 32'({rr_if.i_ack_out, rr_if.d_ack_out}), 32'h0);
            end else begin
               rr_e = rr_q.pop_front();
               chk("rr_ack_port_is_d", 32'(rr_if.d_ack_out), 32'(rr_e.is_d));
               chk("rr_ack_both", 32'(rr_if.i_ack_out && rr_if.d_ack_out), 32'h0);
               chk("rr_ack_pulse", 32'(rr_ack_prev), 32'h0);
               if (rr_e.is_d) chk("rr_d_rdata", rr_if.d_rdata_out, rr_e.rdata);
               else chk("rr_i_rdata", rr_if.i_rdata_out, rr_e.rdata);
               chk("rr_err", 32'(rr_if.err_out), 32'(rr_e.err));
               chk("rr_req_cycles", rr_req_cyc, rr_e.cycles);
            end
         end
      end
      rr_req_prev = rr_if.mem_req_out;
      rr_ack_prev = rr_if.i_ack_out || rr_if.d_ack_out;
   end

   // Grant-order monitor for the fixed-priority instance.
   always @(negedge clk) begin
      if (!rst && (fp_if.i_ack_out || fp_if.d_ack_out)) begin
         if (fp_q.size() == 0) begin
            chk("fp_unexpected_ack", 32'({fp_if.i_ack_out, fp_if.d_ack_out}), 32'h0);
         end else begin
            fp_e = fp_q.pop_front();
            chk("fp_ack_port_is_d", 32'(fp_if.d_ack_out), 32'(fp_e.is_d));
            if (fp_e.is_d) chk("fp_d_rdata", fp_if.d_rdata_out, fp_e.rdata);
            else chk("fp_i_rdata", fp_if.i_rdata_out, fp_e.rdata);
         end
      end
   end

   task automatic rr_push(input bit is_d, input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input bit abort,
                          input int cycles);
      exp_t e;
      e.is_d  = is_d;
      e.addr  = addr;
      e.we    = is_d && we;
      e.wdata = is_d ? wdata : 32'h0;
      e.wstrb = is_d ? wstrb : 4'h0;
      if (abort) rr_err = 1'b1;
      if (is_d && we) begin
         e.rdata = rr_d_rd;
      end else begin
         e.rdata = abort ? 32'h0 : mem_data(addr);
         if (is_d) rr_d_rd = e.rdata;
         else rr_i_rd = e.rdata;
      end
      e.err    = rr_err;
      e.cycles = cycles;
      rr_q.push_back(e);
   endtask

   task automatic rr_single(input bit is_d, input logic [31:0] addr, input bit we,
                            input logic [31:0] wdata, input logic [3:0] wstrb, input bit abort,
                            input int cycles);
      bit ok;
      rr_push(is_d, addr, we, wdata, wstrb, abort, cycles);
      if (is_d) begin
         rr_if.d_addr_in  = addr;
         rr_if.d_we_in    = we;
         rr_if.d_wdata_in = wdata;
         rr_if.d_wstrb_in = wstrb;
         rr_if.d_req_in   = 1'b1;
      end else begin
         rr_if.i_addr_in = addr;
         rr_if.i_req_in  = 1'b1;
      end
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (is_d ? rr_if.d_ack_out : rr_if.i_ack_out) ok = 1'b1;
      end
      rr_if.i_req_in = 1'b0;
      rr_if.d_req_in = 1'b0;
      chk("rr_single_completed", 32'(ok), 32'h1);
   endtask

   // Both ports request reads continuously until n acks have been seen.
   task automatic rr_both(input int n, input bit first_d);
      int acks;
      bit cur_d;
      acks  = 0;
      cur_d = first_d;
      for (int k = 0; k < n; k++) begin
         rr_push(cur_d, cur_d ? 32'h24 : 32'h20, 1'b0, 32'h0, 4'h0, 1'b0, 3);
         cur_d = !cur_d;
      end
      rr_if.i_addr_in  = 32'h20;
      rr_if.d_addr_in  = 32'h24;
      rr_if.d_we_in    = 1'b0;
      rr_if.d_wdata_in = 32'h0;
      rr_if.d_wstrb_in = 4'h0;
      rr_if.i_req_in   = 1'b1;
      rr_if.d_req_in   = 1'b1;
      for (int c = 0; c < 20 * n && acks < n; c++) begin
         @(negedge clk);
         if (rr_if.i_ack_out) acks++;
         if (rr_if.d_ack_out) acks++;
      end
      rr_if.i_req_in = 1'b0;
      rr_if.d_req_in = 1'b0;
      chk("rr_both_acks", acks, n);
   endtask

   task automatic rr_check_zero(input string tag);
      chk({tag, "_mem_req"}, 32'(rr_if.mem_req_out), 32'h0);
      chk({tag, "_mem_we"}, 32'(rr_if.mem_we_out), 32'h0);
      chk({tag, "_mem_addr"}, rr_if.mem_addr_out, 32'h0);
      chk({tag, "_mem_wdata"}, rr_if.mem_wdata_out, 32'h0);
      chk({tag, "_mem_wstrb"}, 32'(rr_if.mem_wstrb_out), 32'h0);
      chk({tag, "_acks"}, 32'({rr_if.i_ack_out, rr_if.d_ack_out}), 32'h0);
      chk({tag, "_i_rdata"}, rr_if.i_rdata_out, 32'h0);
      chk({tag, "_d_rdata"}, rr_if.d_rdata_out, 32'h0);
      chk({tag, "_busy"}, 32'(rr_if.busy_out), 32'h0);
      chk({tag, "_err"}, 32'(rr_if.err_out), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int dacks;
      bit ok;
      rr_if.i_req_in = 1'b0; rr_if.i_addr_in = 32'h0;
      rr_if.d_req_in = 1'b0; rr_if.d_we_in = 1'b0; rr_if.d_addr_in = 32'h0;
      rr_if.d_wdata_in = 32'h0; rr_if.d_wstrb_in = 4'h0;
      fp_if.i_req_in = 1'b0; fp_if.i_addr_in = 32'h0;
      fp_if.d_req_in = 1'b0; fp_if.d_we_in = 1'b0; fp_if.d_addr_in = 32'h0;
      fp_if.d_wdata_in = 32'h0; fp_if.d_wstrb_in = 4'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rr_check_zero("reset");

      // Instruction fetch, then data read and data write (write leaves d_rdata alone).
      rr_single(1'b0, 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 3);
      rr_single(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 3);
      rr_single(1'b1, 32'h100, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 3);
      repeat (2) @(negedge clk);

      // Last grant was D, so continuous contention alternates starting with I.
      rr_both(4, 1'b0);
      repeat (2) @(negedge clk);

      // Memory never answers a data read: abort after 4 wait cycles, err sticks.
      rr_lat = 0;
      rr_single(1'b1, 32'h80, 1'b0, 32'h0, 4'h0, 1'b1, 5);
      rr_lat = 3;
      rr_single(1'b0, 32'h30, 1'b0, 32'h0, 4'h0, 1'b0, 3);
      repeat (3) @(negedge clk);
      chk("rr_err_sticky", 32'(rr_if.err_out), 32'h1);

      // Fixed priority: D keeps winning while it requests; I gets in once D lets go.
      for (int k = 0; k < 3; k++) begin
         fp_e.is_d  = 1'b1;
         fp_e.rdata = mem_data(32'h64);
         fp_q.push_back(fp_e);
      end
      fp_if.i_addr_in = 32'h60;
      fp_if.d_addr_in = 32'h64;
      fp_if.i_req_in  = 1'b1;
      fp_if.d_req_in  = 1'b1;
      dacks = 0;
      for (int c = 0; c < 60 && dacks < 3; c++) begin
         @(negedge clk);
         if (fp_if.d_ack_out) dacks++;
      end
      chk("fp_d_acks", dacks, 3);
      fp_e.is_d  = 1'b0;
      fp_e.rdata = mem_data(32'h60);
      fp_q.push_back(fp_e);
      fp_if.d_req_in = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (fp_if.i_ack_out) ok = 1'b1;
      end
      fp_if.i_req_in = 1'b0;
      chk("fp_i_completed", 32'(ok), 32'h1);
      repeat (2) @(negedge clk);

      // Reset in the middle of an instruction grant, then a stray memory ack.
      rr_lat = 0;
      rr_push(1'b0, 32'h50, 1'b0, 32'h0, 4'h0, 1'b0, 0);
      rr_if.i_addr_in = 32'h50;
      rr_if.i_req_in  = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (rr_if.mem_req_out) ok = 1'b1;
      end
      chk("rr_grant_before_reset", 32'(ok), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      rr_if.i_req_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rr_q.delete();
      rr_i_rd = 32'h0;
      rr_d_rd = 32'h0;
      rr_err  = 1'b0;
      rr_check_zero("midreset");
      rr_force = 1'b1;
      repeat (2) @(negedge clk);
      rr_force = 1'b0;
      repeat (3) @(negedge clk);
      chk("rr_idle_after_stray_ack", 32'(rr_if.busy_out), 32'h0);
      rr_lat = 3;
      rr_both(2, 1'b0);
      repeat (3) @(negedge clk);

      chk("rr_queue_drained", rr_q.size(), 0);
      chk("fp_queue_drained", fp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
